// File: rtl/alu_pkg.sv
// Opcode encodings shared with the board ALU, button index constants and opcode legality helper.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SRA = 6'b000011;
  localparam logic [5:0] ALU_SRL = 6'b000010;
  localparam logic [5:0] ALU_NOR = 6'b100111;

  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  // Zero-extended compare so callers with any switch width up to 32 can use it.
  function automatic logic is_legal_op(input logic [31:0] op);
    return op inside {32'(ALU_ADD), 32'(ALU_SUB), 32'(ALU_AND), 32'(ALU_OR),
                      32'(ALU_XOR), 32'(ALU_SRA), 32'(ALU_SRL), 32'(ALU_NOR)};
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stable-count debounce, registered rising-edge pulse.
module btn_debouncer #(
  parameter int unsigned DB_COUNT = 1000000,
  parameter int unsigned DB_W     = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic            sync0;
  logic            sync1;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      o_pulse <= 1'b0;
    end else begin
      sync0   <= i_btn;
      sync1   <= sync0;
      level_d <= level;
      o_pulse <= level & ~level_d;
      // Level flips on the DB_COUNT-th consecutive differing cycle.
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_COUNT - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Loads ALU operands A/B and opcode from slide switches via three debounced buttons.
// Optional opcode legality check: define OPERAND_LOADER_OP_CHECK_EN.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS   = 6,
  parameter int unsigned DB_COUNT = 1000000,
  parameter int unsigned DB_W     = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic [2:0]        i_btn,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_OP,
  output logic              o_valid,
  output logic [2:0]        o_loaded,
  output logic              o_err
);

  logic [2:0] pulse;
  logic [2:0] cap;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debouncer #(
      .DB_COUNT (DB_COUNT),
      .DB_W     (DB_W)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (i_btn[g]),
      .o_pulse (pulse[g])
    );
  end

  always_comb begin
    cap = pulse;
`ifdef OPERAND_LOADER_OP_CHECK_EN
    if (!is_legal_op(32'(i_sw))) cap[BTN_OP] = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      o_A      <= '0;
      o_B      <= '0;
      o_OP     <= '0;
      o_loaded <= '0;
      o_valid  <= 1'b0;
    end else begin
      if (cap[BTN_A])  o_A  <= i_sw;
      if (cap[BTN_B])  o_B  <= i_sw;
      if (cap[BTN_OP]) o_OP <= i_sw;
      o_valid <= &o_loaded;
      // Issue clears the flags, but a capture on the issuing edge re-arms its own bit.
      o_loaded <= ((&o_loaded) ? 3'b000 : o_loaded) | cap;
    end
  end

`ifdef OPERAND_LOADER_OP_CHECK_EN
  always_ff @(posedge clock) begin
    if (!reset) o_err <= 1'b0;
    else        o_err <= pulse[BTN_OP] & ~cap[BTN_OP];
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the board-level ALU.
- Captures operand A, operand B and the 6-bit opcode from the board slide switches, using three push-buttons, one per field.
- Each button is synchronised, debounced and edge-detected; the captured fields are then presented to the ALU as stable registered values.
- Issues a one-cycle o_valid strobe when a complete A/B/OP set has been loaded.

Parameters:
- N_BITS, 6, width of the switch bus, the operands and the opcode.
- DB_COUNT, 1000000, consecutive stable cycles needed before a button change is accepted (10 ms at 100 MHz). Minimum value is 2.
- DB_W, 20, counter width. Must satisfy 2^DB_W > DB_COUNT.

Ports:
- clock, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- i_sw, input, N_BITS, slide switches. Asynchronous to clock; sampled only on a load pulse.
- i_btn, input, 3, raw push-buttons, asynchronous. Bit 0 loads A, bit 1 loads B, bit 2 loads OP.
- o_A, output, N_BITS, registered operand A.
- o_B, output, N_BITS, registered operand B.
- o_OP, output, N_BITS, registered opcode.
- o_valid, output, 1, one-cycle strobe: a full set has been loaded.
- o_loaded, output, 3, per-field loaded flags, using the same bit order as i_btn.
- o_err, output, 1, one-cycle illegal-opcode strobe. Present only with the optional feature; otherwise tied to 0.

Behaviour:
- Reset is sampled at a rising clock edge while reset is 0. It clears o_A, o_B, o_OP, o_loaded, o_valid and o_err to 0. It also clears all synchroniser flops, debounced levels and debounce counters. Reset mid-debounce or with partial flags discards all progress.
- Synchroniser: each i_btn bit passes through two flops before any other use.
- Debounce, per button:
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter is at DB_COUNT-1 and the levels still differ, the debounced level flips and the counter clears.
  - Net effect: a change is accepted after exactly DB_COUNT consecutive differing cycles. Glitches shorter than that are ignored.
- Edge detect: a registered load pulse lasts exactly one cycle. It is asserted in the cycle after the debounced level goes 0 to 1. Releasing the button produces no pulse.
- Capture:
  - At the edge ending a load pulse, i_sw is written into the matching field and that field's o_loaded bit is set.
  - Reloading an already-loaded field overwrites its value; its flag stays set.
  - Simultaneous pulses all capture the same i_sw value.
- Issue:
  - At the first edge where all three o_loaded bits are 1, o_valid goes high for one cycle and o_loaded clears to 0 at that same edge.
  - o_A, o_B and o_OP keep their values after issue and change only on a new capture.
  - A load pulse arriving in the cycle o_valid is high still captures, and its flag is set for the next set. Capture has priority over the clear, for that bit only.
- Latency: raw press edge to o_loaded bit set is 2 + DB_COUNT + 2 cycles.
- The switches are not double-registered. Users must keep them static while pressing a button.

Optional Feature:
- Macro: OPERAND_LOADER_OP_CHECK_EN.
- When defined:
  - An OP load whose i_sw value is not one of the 8 legal ALU opcodes leaves o_OP and o_loaded[2] unchanged.
  - It pulses o_err for one cycle, in the cycle after the load pulse.
  - Legal opcodes are 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL and 100111 NOR.
- When undefined: any value is accepted and o_err is constant 0.

Decomposition:
- Shared package alu_pkg:
  - the eight opcode localparams, shared with the ALU;
  - the button index constants BTN_A=0, BTN_B=1, BTN_OP=2.
- Sub-module btn_debouncer, parameters DB_COUNT and DB_W:
  - contains the 2-flop synchroniser, the debounce counter and the rising-edge pulse;
  - ports clock, reset, i_btn, o_pulse;
  - instantiated three times.

Test Plan (DB_COUNT=4, DB_W=3):
- Reset: hold reset=0 for 3 cycles with buttons pressed. All outputs are 0; no pulse follows release of reset until each button has been stable for 4 cycles.
- Full load: i_sw=000101 then press btn0; i_sw=000011 then press btn1; i_sw=100000 then press btn2. Expect o_A=5, o_B=3, o_OP=100000, a single o_valid pulse, then o_loaded=000. The downstream ALU produces 8.
- Bounce: toggle btn0 with a period of 3 cycles for 20 cycles, then hold it high. Exactly one load occurs, 2+4+2 cycles after the final rise.
- Overwrite: load A=7, then reload A=2 before loading B or OP. o_loaded[0] stays 1; after B and OP are loaded, o_A=2 and o_valid pulses once.
- Simultaneous: i_sw=010101 and all three buttons pressed together. All fields equal 010101 and o_valid pulses once, one cycle after the flags set.
- With OPERAND_LOADER_OP_CHECK_EN: loading OP=111111 pulses o_err; o_OP and o_loaded[2] are unchanged. A following load of OP=100010 is accepted.
